// File: rtl/pong_game_sequencer_if.sv
// pong_game_sequencer_if: game-control signal bundle; the pause input exists only when PONG_PAUSE_EN is defined.
interface pong_game_sequencer_if;
  logic [9:0] ypos;
  logic       start, hit, miss;
`ifdef PONG_PAUSE_EN
  logic       pause;
`endif
  logic       paddle_en, ball_en, collide_en, ball_reset, game_over;
  logic [2:0] state, level;
  logic [7:0] score;
  logic [1:0] lives_left;
`ifdef PONG_PAUSE_EN
  modport master(output ypos, start, hit, miss, pause,
                 input paddle_en, ball_en, collide_en, ball_reset, game_over, state, level, score, lives_left);
  modport slave(input ypos, start, hit, miss, pause,
                output paddle_en, ball_en, collide_en, ball_reset, game_over, state, level, score, lives_left);
`else
  modport master(output ypos, start, hit, miss,
                 input paddle_en, ball_en, collide_en, ball_reset, game_over, state, level, score, lives_left);
  modport slave(input ypos, start, hit, miss,
                output paddle_en, ball_en, collide_en, ball_reset, game_over, state, level, score, lives_left);
`endif
endinterface

// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer: frame-timed paddle/ball/collide strobes plus serve/play/miss/over game FSM.
// Optional PONG_PAUSE_EN adds a pause toggle input active in PLAY.
module pong_game_sequencer #(
  parameter logic [9:0] NumberofLines = 10'd480,
  parameter logic [7:0] ServeFrames   = 8'd60,
  parameter logic [1:0] Lives         = 2'd3,
  parameter logic [2:0] HitsPerLevel  = 3'd4
) (
  input logic clk,
  input logic rst,
  pong_game_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, MISS = 3'd3, OVER = 3'd4;
  logic [9:0] ypos_q;
  logic [2:0] state_q, state_d, level_q, level_d, hits_q, hits_d;
  logic [7:0] serve_q, serve_d, score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic       paused_q, paused_d, paddle_q, paddle_d, play1_q, play1_d, ball_q, collide_q;
  logic       frame_tick, pause_in, level_up;
`ifdef PONG_PAUSE_EN
  assign pause_in = bus.pause;
`else
  assign pause_in = 1'b0;
`endif
  assign frame_tick = (bus.ypos == NumberofLines) && (ypos_q != NumberofLines);
  assign level_up   = (hits_q + 3'd1) == HitsPerLevel;
  always_ff @(posedge clk) begin
    if (rst) begin
      ypos_q    <= '0;
      state_q   <= IDLE;
      serve_q   <= '0;
      score_q   <= '0;
      lives_q   <= '0;
      level_q   <= '0;
      hits_q    <= '0;
      paused_q  <= 1'b0;
      paddle_q  <= 1'b0;
      play1_q   <= 1'b0;
      ball_q    <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      ypos_q    <= bus.ypos;
      state_q   <= state_d;
      serve_q   <= serve_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      hits_q    <= hits_d;
      paused_q  <= paused_d;
      paddle_q  <= paddle_d;
      play1_q   <= play1_d;
      ball_q    <= play1_q;
      collide_q <= ball_q;
    end
  end
  always_comb begin
    state_d = state_q;
    serve_d = serve_q;
    score_d = score_q;
    lives_d = lives_q;
    level_d = level_q;
    hits_d  = hits_q;
    case (state_q)
      IDLE, OVER: if (bus.start) begin
        state_d = SERVE;
        serve_d = ServeFrames - 8'd1;
        score_d = '0;
        level_d = '0;
        hits_d  = '0;
        lives_d = Lives;
      end
      SERVE: if (frame_tick) begin
        state_d = serve_q == 8'd0 ? PLAY : SERVE;
        serve_d = serve_q == 8'd0 ? 8'd0 : serve_q - 8'd1;
      end
      PLAY: if (!paused_q && bus.miss) begin
        state_d = lives_q > 2'd1 ? MISS : OVER;
        lives_d = lives_q > 2'd1 ? lives_q - 2'd1 : 2'd0;
      end else if (!paused_q && bus.hit) begin
        score_d = score_q == 8'hff ? score_q : score_q + 8'd1;
        hits_d  = level_up ? 3'd0 : hits_q + 3'd1;
        level_d = level_up && level_q != 3'd7 ? level_q + 3'd1 : level_q;
      end
      MISS: if (frame_tick) begin
        state_d = SERVE;
        serve_d = ServeFrames - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    paused_d = (state_q == PLAY && state_d == PLAY) ? paused_q ^ pause_in : 1'b0;
  end
  // the state seen on the tick cycle decides the whole three-strobe sequence
  always_comb begin
    paddle_d       = frame_tick && (state_q == SERVE || state_q == PLAY) && !paused_q;
    play1_d        = frame_tick && state_q == PLAY && !paused_q;
    bus.paddle_en  = paddle_q;
    bus.ball_en    = ball_q;
    bus.collide_en = collide_q;
    bus.ball_reset = state_q != PLAY;
    bus.game_over  = state_q == OVER;
    bus.state      = state_q;
    bus.score      = score_q;
    bus.lives_left = lives_q;
    bus.level      = level_q;
  end
endmodule

// File: tb/tb_pong_game_sequencer.sv
// tb_pong_game_sequencer: directed game scenarios; expected strobes queued by stimulus and matched by a monitor.
module tb_pong_game_sequencer;
  typedef struct {logic [2:0] k; int c;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, n_chk = 0, n_pass = 0;
  exp_t q[$];
  pong_game_sequencer_if bus();
  pong_game_sequencer #(.ServeFrames(8'd2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input bit p, input bit b);
    for (int y = 0; y < 525; y++) begin
      bus.ypos = 10'(y);
      if (y == 480) begin
        if (p) q.push_back('{3'b001, cyc + 1});
        if (b) begin
          q.push_back('{3'b010, cyc + 2});
          q.push_back('{3'b100, cyc + 3});
        end
      end
      step();
    end
  endtask
  task automatic press(input bit s, input bit h, input bit m);
    bus.start = s;
    bus.hit = h;
    bus.miss = m;
    step();
    bus.start = 1'b0;
    bus.hit = 1'b0;
    bus.miss = 1'b0;
    step();
  endtask
  always @(negedge clk) begin
    logic [2:0] k;
    k = {bus.collide_en, bus.ball_en, bus.paddle_en};
    while (q.size() > 0 && q[0].c < cyc) begin
      n_chk++;
      $display("FAIL strobe_missing: kind %b due at cycle %0d never seen", q[0].k, q[0].c);
      void'(q.pop_front());
    end
    if (k != 3'b000) begin
      n_chk++;
      if (q.size() == 0) $display("FAIL strobe_unexpected: got %b at cycle %0d, expected none", k, cyc);
      else begin
        if (q[0].k == k && q[0].c == cyc) n_pass++;
        else $display("FAIL strobe: got %b at cycle %0d expected %b at cycle %0d", k, cyc, q[0].k, q[0].c);
        void'(q.pop_front());
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    bus.ypos = '0;
    bus.start = 1'b0;
    bus.hit = 1'b0;
    bus.miss = 1'b0;
`ifdef PONG_PAUSE_EN
    bus.pause = 1'b0;
`endif
    repeat (3) step();
    chk("rst_state", bus.state, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_lives", bus.lives_left, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_game_over", bus.game_over, 0);
    chk("rst_ball_reset", bus.ball_reset, 1);
    chk("rst_strobes", {bus.paddle_en, bus.ball_en, bus.collide_en}, 0);
    rst = 1'b0;
    frame(0, 0);
    chk("idle_state", bus.state, 0);
    press(1, 0, 0);
    chk("start_state", bus.state, 1);
    chk("start_lives", bus.lives_left, 3);
    press(0, 1, 0);
    chk("serve_hit_ignored", bus.score, 0);
    frame(1, 0);
    chk("serve_after_tick1", bus.state, 1);
    frame(1, 0);
    chk("play_after_tick2", bus.state, 2);
    chk("play_ball_reset", bus.ball_reset, 0);
    frame(1, 1);
    repeat (9) press(0, 1, 0);
    chk("score_9", bus.score, 9);
    chk("level_2", bus.level, 2);
    repeat (251) press(0, 1, 0);
    chk("score_sat", bus.score, 255);
    chk("level_sat", bus.level, 7);
    press(0, 0, 1);
    chk("miss1_state", bus.state, 3);
    chk("miss1_lives", bus.lives_left, 2);
    chk("miss_ball_reset", bus.ball_reset, 1);
    frame(0, 0);
    chk("reserve_state", bus.state, 1);
    frame(1, 0);
    frame(1, 0);
    chk("replay_state", bus.state, 2);
    chk("score_kept", bus.score, 255);
    press(0, 0, 1);
    chk("miss2_lives", bus.lives_left, 1);
    frame(0, 0);
    frame(1, 0);
    frame(1, 0);
    press(0, 0, 1);
    chk("miss3_lives", bus.lives_left, 0);
    chk("over_state", bus.state, 4);
    chk("over_flag", bus.game_over, 1);
    press(0, 1, 0);
    chk("over_hit_ignored", bus.score, 255);
    frame(0, 0);
    press(1, 0, 0);
    chk("restart_state", bus.state, 1);
    chk("restart_score", bus.score, 0);
    chk("restart_lives", bus.lives_left, 3);
    chk("restart_level", bus.level, 0);
    frame(1, 0);
    frame(1, 0);
    repeat (5) press(0, 1, 0);
    chk("score_5", bus.score, 5);
    press(0, 1, 1);
    chk("hit_miss_score", bus.score, 5);
    chk("hit_miss_state", bus.state, 3);
    frame(0, 0);
    frame(1, 0);
    frame(1, 0);
    chk("play_again", bus.state, 2);
`ifdef PONG_PAUSE_EN
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    step();
    repeat (3) frame(0, 0);
    press(0, 1, 0);
    chk("paused_hit_ignored", bus.score, 5);
    chk("paused_state", bus.state, 2);
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    step();
    frame(1, 1);
`endif
    for (int y = 470; y <= 480; y++) begin
      bus.ypos = 10'(y);
      if (y == 480) q.push_back('{3'b001, cyc + 1});
      step();
    end
    rst = 1'b1;
    bus.ypos = 10'd481;
    step();
    rst = 1'b0;
    for (int y = 482; y < 525; y++) begin
      bus.ypos = 10'(y);
      step();
    end
    chk("midseq_rst_state", bus.state, 0);
    frame(0, 0);
    repeat (5) step();
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pong_game_sequencer.md
PONG_GAME_SEQUENCER -- requirements
Module: pong_game_sequencer

Interface
REQ-001 Parameter NumberofLines, default 10'd480, first blanking line; frame tick fires on entry to this line.
REQ-002 Parameter ServeFrames, default 8'd60, frames spent in SERVE before play.
REQ-003 Parameter Lives, default 2'd3, lives per game.
REQ-004 Parameter HitsPerLevel, default 3'd4, paddle hits per speed-level increment.
REQ-005 Clock  input  1  system clock, 100 MHz.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 ypos  input  10  current line from the CRT controller.
REQ-008 start  input  1  one-cycle start pulse, debounced upstream.
REQ-009 hit  input  1  one-cycle pulse: ball struck the paddle.
REQ-010 miss  input  1  one-cycle pulse: ball left the field.
REQ-011 paddle_en  output  1  one-cycle paddle-update strobe.
REQ-012 ball_en  output  1  one-cycle ball-move strobe.
REQ-013 collide_en  output  1  one-cycle collision-check strobe.
REQ-014 ball_reset  output  1  holds the ball at its serve position.
REQ-015 state  output  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
REQ-016 score  output  8  hit count, binary.
REQ-017 lives_left  output  2  remaining lives.
REQ-018 level  output  3  speed level, 0..7.
REQ-019 game_over  output  1  high while in OVER.

Function
REQ-020 ypos registered each cycle; frame_tick, internal, SHALL be high for exactly one cycle when ypos==NumberofLines and the registered previous ypos!=NumberofLines.
REQ-021 Strobe sequence after frame_tick in cycle T: paddle_en at T+1, ball_en at T+2, collide_en at T+3, each exactly one cycle, all registered.
REQ-022 paddle_en SHALL issue only in SERVE or PLAY; ball_en and collide_en only in PLAY; the state sampled at T gates the whole sequence.
REQ-023 IDLE: ball_reset=1; start -> SERVE, with score=0, level=0, hit counter=0, lives_left=Lives.
REQ-024 SERVE: ball_reset=1; serve counter loads ServeFrames-1 on entry and decrements on each frame_tick; a frame_tick with counter==0 -> PLAY.
REQ-025 PLAY: ball_reset=0; hit -> score+1 (saturating at 255) and hit counter+1; when the hit counter reaches HitsPerLevel it clears and level+1 (saturating at 7).
REQ-026 PLAY: miss with lives_left>1 -> lives_left-1 and MISS; miss with lives_left==1 -> lives_left=0 and OVER.
REQ-027 hit and miss in the same cycle: miss wins; the hit is discarded, with no score change.
REQ-028 MISS: ball_reset=1; next frame_tick -> SERVE, reloading the serve counter; score and level kept.
REQ-029 OVER: game_over=1, ball_reset=1; start -> SERVE with the same clearing as REQ-023.
REQ-030 hit and miss outside PLAY ignored; start outside IDLE and OVER ignored.
REQ-031 Illegal state encodings (5-7) SHALL recover to IDLE on the next clock.

Reset
REQ-032 Reset high at a rising edge: state=IDLE, score=0, level=0, lives_left=0, all counters=0, all strobes=0, game_over=0, ball_reset=1; registered ypos=0.
REQ-033 Reset mid-sequence SHALL cancel any pending strobes; none issue after reset releases until a new frame_tick.

Configuration
REQ-034 Macro PONG_PAUSE_EN defined: adds input pause (one-cycle pulse); in PLAY each pulse toggles a paused flag; the flag clears on leaving PLAY and on reset.
REQ-035 While paused: no strobes; hit and miss ignored; state and counters hold.
REQ-036 PONG_PAUSE_EN undefined: no pause port; behaviour exactly as REQ-020..REQ-033.

Verification
REQ-037 Reset, ServeFrames=2, ypos sweeping 0..524 repeatedly, start pulse -> SERVE; PLAY after the 2nd frame_tick; during SERVE only paddle_en, at T+1.
REQ-038 In PLAY, one frame -> paddle_en, ball_en, collide_en at T+1, T+2, T+3, each exactly one cycle; no strobes at other cycles of the frame.
REQ-039 In PLAY, 9 hit pulses -> score=9, level=2; 260 hits -> score=255.
REQ-040 Lives=3, three misses each followed by re-serve -> lives_left 2, 1 then 0, game_over=1, state=4; then start -> state=1, score=0, lives_left=3.
REQ-041 hit and miss in the same cycle with score=5 -> score stays 5, state=MISS; Reset asserted at T+1 of a strobe sequence -> no ball_en or collide_en, state=IDLE.
REQ-042 With PONG_PAUSE_EN: pause in PLAY -> no strobes for the next 3 frames and hits ignored; second pause -> strobes resume at the next frame_tick.
